seg_scan_ctrl: RTL

// - Time-multiplexes one shared BCD->7-seg decoder (bcd_seg_disp, common-anode) across DIGITS fare digits.
// - Holds a shadow copy of the fare value and steps through the digit slots: feeds the decoder one BCD nibble
//   and drives one active-low anode enable per slot.
// - Sits between the fare datapath (BCD digits + max flag) and the display pins.
// - Updates the shadow copy only at frame boundaries, so a change in value never tears across digits.
//

---
 rtl/seg_scan_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// Scans a shadowed BCD fare value across DIGITS common-anode digits through one shared decoder.
// Optional leading-zero blanking: define SEG_SCAN_LZB_EN.
module seg_scan_ctrl #(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned DIV       = 50000,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  max_in,
  input  logic                  upd,
  output logic                  upd_ack,
  output logic [3:0]            bcd_out,
  output logic                  max_out,
  output logic [DIGITS-1:0]     dig_an,
  output logic                  frame_end
);

  localparam int unsigned CW = $clog2(DIV);
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST       = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK_LAST = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST       = IW'(DIGITS - 1);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;
  localparam state_t ST_INIT = (BLANK_CYC == 0) ? ST_SHOW : ST_BLANK;

  state_t                 st;
  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;
  logic [DIGITS-1:0][3:0] shadow;
  logic                   shadow_max;
  logic                   pend;
  logic                   ack_dly;

  logic                   boundary_c;
  logic                   lit_c;

  assign boundary_c = (cnt == CNT_LAST) && (idx == IDX_LAST);

`ifdef SEG_SCAN_LZB_EN
  // lz_c[i]: shadow digits i..DIGITS-1 are all zero
  logic [DIGITS-1:0] lz_c;
  always_comb begin
    lz_c = '0;
    lz_c[DIGITS-1] = (shadow[DIGITS-1] == 4'd0);
    for (int i = int'(DIGITS) - 2; i >= 0; i--) begin
      lz_c[i] = lz_c[i+1] && (shadow[i] == 4'd0);
    end
  end
  assign lit_c = (idx == '0) || shadow_max || !lz_c[idx];
`else
  assign lit_c = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= ST_INIT;
      cnt        <= '0;
      idx        <= '0;
      shadow     <= '0;
      shadow_max <= 1'b0;
      pend       <= 1'b0;
      ack_dly    <= 1'b0;
      upd_ack    <= 1'b0;
      bcd_out    <= 4'd0;
      max_out    <= 1'b0;
      dig_an     <= '1;
      frame_end  <= 1'b0;
    end else begin
      bcd_out   <= shadow[idx];
      max_out   <= shadow_max;
      frame_end <= 1'b0;
      ack_dly   <= 1'b0;
      upd_ack   <= ack_dly;
      if (!en) begin
        // Idle: dark display, restart at slot 0; capture now, ack one edge later
        st     <= ST_INIT;
        cnt    <= '0;
        idx    <= '0;
        dig_an <= '1;
        if (pend || upd) begin
          shadow     <= bcd_in;
          shadow_max <= max_in;
          pend       <= 1'b0;
          ack_dly    <= 1'b1;
        end
      end else begin
        dig_an <= (st == ST_SHOW && lit_c) ? ~(DIGITS'(1) << idx) : '1;
        if (cnt == CNT_LAST) begin
          cnt <= '0;
          idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
          st  <= ST_INIT;
        end else begin
          cnt <= cnt + CW'(1);
          if (BLANK_CYC > 0 && cnt == CNT_BLANK_LAST) begin
            st <= ST_SHOW;
          end
        end
        // Shadow only changes between frames so digits never tear
        if (boundary_c) begin
          frame_end <= 1'b1;
          if (pend || upd) begin
            shadow     <= bcd_in;
            shadow_max <= max_in;
            pend       <= 1'b0;
            upd_ack    <= 1'b1;
          end
        end else if (upd) begin
          pend <= 1'b1;
        end
      end
    end
  end

endmodule
